// File: rtl/kick_input_latch_pkg.sv
// kick_input_latch_pkg: lane encodings, FSM states and LFSR constants for the kick input latch.
package kick_input_latch_pkg;
  localparam logic [1:0] LANE_NONE  = 2'd0;
  localparam logic [1:0] LANE_LEFT  = 2'd1;
  localparam logic [1:0] LANE_MID   = 2'd2;
  localparam logic [1:0] LANE_RIGHT = 2'd3;
  localparam logic [7:0] LFSR_SEED  = 8'hA5;
  // Feedback mask for taps 8,6,5,4 (bits 7,5,4,3).
  localparam logic [7:0] LFSR_TAPS  = 8'hB8;
  typedef enum logic [1:0] {IDLE, ARMED, LOCKED} state_t;
  function automatic logic [1:0] lane_or_left(input logic [1:0] v);
    return (v == LANE_NONE) ? LANE_LEFT : v;
  endfunction
endpackage

// File: rtl/kick_input_latch_lane_debounce.sv
// lane_debounce: 2-flop synchronizer plus saturating tick-driven debounce for one 2-bit lane bus.
module lane_debounce #(
  parameter int DEB_TICKS = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic [1:0] raw,
  output logic [1:0] deb
);
  localparam int CW = $clog2(DEB_TICKS + 1);
  logic [1:0] sync_a, sync_b, cand;
  logic [CW-1:0] cnt;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_a <= '0;
      sync_b <= '0;
      cand   <= '0;
      cnt    <= '0;
      deb    <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      // A differing sample restarts the run and counts as its first sample.
      if (sample_tick)
        if (sync_b != cand) begin
          cand <= sync_b;
          cnt  <= CW'(1);
        end else if (cnt != CW'(DEB_TICKS))
          cnt <= cnt + CW'(1);
      if (cnt == CW'(DEB_TICKS))
        deb <= cand;
    end
  end
endmodule

// File: rtl/kick_input_latch.sv
// kick_input_latch: debounces both players' lane switches, captures first choices, freezes them at window close.
// Optional macro KICK_RAND_DEFAULT_EN: LFSR-derived lane replaces DEFAULT_LANE for a missing choice.
module kick_input_latch
  import kick_input_latch_pkg::*;
#(
  parameter int         DEB_TICKS    = 20,
  parameter logic [1:0] DEFAULT_LANE = LANE_MID
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic       round_start,
  input  logic       window_close,
  input  logic [1:0] ball_raw,
  input  logic [1:0] gp_raw,
  output logic [1:0] ball_sel,
  output logic [1:0] gp_sel,
  output logic       sel_valid,
  output logic       kicker_ready,
  output logic       keeper_ready
);
  state_t state, state_nxt;
  logic [1:0] ball_deb, gp_deb, ball_hold, gp_hold, ball_dflt, gp_dflt, ball_lock, gp_lock;
  logic armed, ball_take, gp_take, lock;

  lane_debounce #(.DEB_TICKS(DEB_TICKS)) u_ball (
    .clock(clock), .reset(reset), .sample_tick(sample_tick), .raw(ball_raw), .deb(ball_deb)
  );
  lane_debounce #(.DEB_TICKS(DEB_TICKS)) u_gp (
    .clock(clock), .reset(reset), .sample_tick(sample_tick), .raw(gp_raw), .deb(gp_deb)
  );

`ifdef KICK_RAND_DEFAULT_EN
  logic [7:0] lfsr;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lfsr <= LFSR_SEED;
    else lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
  end
  assign ball_dflt = lane_or_left(lfsr[1:0]);
  assign gp_dflt   = lane_or_left(lfsr[3:2]);
`else
  assign ball_dflt = DEFAULT_LANE;
  assign gp_dflt   = DEFAULT_LANE;
`endif

  always_comb begin
    state_nxt = state;
    if (round_start) state_nxt = ARMED;
    else if (state == ARMED && window_close) state_nxt = LOCKED;
  end

  assign armed     = (state == ARMED) && !round_start;
  assign ball_take = armed && !kicker_ready && ball_deb != LANE_NONE;
  assign gp_take   = armed && !keeper_ready && gp_deb != LANE_NONE;
  assign lock      = armed && window_close;
  // A choice debouncing in the closing cycle still counts.
  assign ball_lock = kicker_ready ? ball_hold : ball_take ? ball_deb : ball_dflt;
  assign gp_lock   = keeper_ready ? gp_hold : gp_take ? gp_deb : gp_dflt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      ball_hold    <= LANE_NONE;
      gp_hold      <= LANE_NONE;
      kicker_ready <= 1'b0;
      keeper_ready <= 1'b0;
      ball_sel     <= LANE_NONE;
      gp_sel       <= LANE_NONE;
      sel_valid    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (round_start) begin
        ball_hold    <= LANE_NONE;
        gp_hold      <= LANE_NONE;
        kicker_ready <= 1'b0;
        keeper_ready <= 1'b0;
        sel_valid    <= 1'b0;
      end else begin
        if (ball_take) begin
          ball_hold    <= ball_deb;
          kicker_ready <= 1'b1;
        end
        if (gp_take) begin
          gp_hold      <= gp_deb;
          keeper_ready <= 1'b1;
        end
        if (lock) begin
          ball_sel  <= ball_lock;
          gp_sel    <= gp_lock;
          sel_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_kick_input_latch.sv
// tb_kick_input_latch: directed self-checking bench for kick_input_latch (honours KICK_RAND_DEFAULT_EN).
module tb_kick_input_latch;
  logic clock = 0, reset = 0, sample_tick = 0, round_start = 0, window_close = 0;
  logic [1:0] ball_raw = 0, gp_raw = 0, ball_sel, gp_sel;
  logic sel_valid, kicker_ready, keeper_ready;
  logic [7:0] m_lfsr, lock_l;
  int total = 0, bad = 0;

  kick_input_latch dut (
    .clock(clock), .reset(reset), .sample_tick(sample_tick), .round_start(round_start),
    .window_close(window_close), .ball_raw(ball_raw), .gp_raw(gp_raw), .ball_sel(ball_sel),
    .gp_sel(gp_sel), .sel_valid(sel_valid), .kicker_ready(kicker_ready), .keeper_ready(keeper_ready)
  );

  always #5 clock = ~clock;

  // Reference LFSR: x^8+x^6+x^5+x^4, seed A5, one step per clock.
  always @(posedge clock or negedge reset)
    if (!reset) m_lfsr <= 8'hA5;
    else m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};

  function automatic logic [1:0] dflt_b();
`ifdef KICK_RAND_DEFAULT_EN
    return (lock_l[1:0] == 2'd0) ? 2'd1 : lock_l[1:0];
`else
    return 2'd2;
`endif
  endfunction

  function automatic logic [1:0] dflt_g();
`ifdef KICK_RAND_DEFAULT_EN
    return (lock_l[3:2] == 2'd0) ? 2'd1 : lock_l[3:2];
`else
    return 2'd2;
`endif
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      sample_tick = 1;
      @(negedge clock);
      sample_tick = 0;
      @(negedge clock);
    end
  endtask

  task automatic settle(input logic [1:0] b, input logic [1:0] g, input int n);
    ball_raw = b;
    gp_raw = g;
    repeat (3) @(negedge clock);
    ticks(n);
    repeat (3) @(negedge clock);
  endtask

  task automatic pulse(input logic rs, input logic wc);
    lock_l = m_lfsr;
    round_start = rs;
    window_close = wc;
    @(negedge clock);
    round_start = 0;
    window_close = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ball"}, 8'(ball_sel), 8'd0);
    chk({tag, "_gp"}, 8'(gp_sel), 8'd0);
    chk({tag, "_valid"}, 8'(sel_valid), 8'd0);
    chk({tag, "_krdy"}, 8'(kicker_ready), 8'd0);
    chk({tag, "_grdy"}, 8'(keeper_ready), 8'd0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk_zero("rst");
    reset = 1;
    @(negedge clock);
    pulse(0, 1);
    repeat (2) @(negedge clock);
    chk("idle_wc_valid", 8'(sel_valid), 8'd0);

    pulse(1, 0);
    settle(2'd2, 2'd3, 20);
    chk("r1_krdy", 8'(kicker_ready), 8'd1);
    chk("r1_grdy", 8'(keeper_ready), 8'd1);
    chk("r1_prevalid", 8'(sel_valid), 8'd0);
    pulse(0, 1);
    chk("r1_ball", 8'(ball_sel), 8'd2);
    chk("r1_gp", 8'(gp_sel), 8'd3);
    chk("r1_valid", 8'(sel_valid), 8'd1);

    settle(2'd1, 2'd0, 20);
    chk("frozen_ball", 8'(ball_sel), 8'd2);
    chk("frozen_valid", 8'(sel_valid), 8'd1);
    pulse(1, 0);
    chk("r2_valid_drop", 8'(sel_valid), 8'd0);
    chk("r2_krdy_clr", 8'(kicker_ready), 8'd0);
    @(negedge clock);
    chk("r2_krdy", 8'(kicker_ready), 8'd1);
    chk("r2_grdy", 8'(keeper_ready), 8'd0);
    settle(2'd3, 2'd0, 40);
    pulse(0, 1);
    chk("r2_first_wins", 8'(ball_sel), 8'd1);
    chk("r2_gp_dflt", 8'(gp_sel), 8'(dflt_g()));

    settle(2'd0, 2'd0, 20);
    pulse(1, 0);
    for (int i = 0; i < 20; i++) begin
      ball_raw = i[0] ? 2'd2 : 2'd1;
      ticks(5);
    end
    ball_raw = 0;
    gp_raw = 2'd1;
    repeat (3) @(negedge clock);
    ticks(19);
    sample_tick = 1;
    @(negedge clock);
    sample_tick = 0;
    @(negedge clock);
    chk("r3_pre_grdy", 8'(keeper_ready), 8'd0);
    pulse(0, 1);
    chk("r3_krdy", 8'(kicker_ready), 8'd0);
    chk("r3_ball_dflt", 8'(ball_sel), 8'(dflt_b()));
    chk("r3_gp_lastcycle", 8'(gp_sel), 8'd1);
    chk("r3_grdy", 8'(keeper_ready), 8'd1);
    chk("r3_valid", 8'(sel_valid), 8'd1);

    settle(2'd0, 2'd0, 20);
    pulse(1, 1);
    chk("both_valid", 8'(sel_valid), 8'd0);
    chk("both_grdy", 8'(keeper_ready), 8'd0);
    chk("both_ball_hold", 8'(ball_sel), 8'(dflt_b()));
    repeat (4) @(negedge clock);
    chk("both_not_locked", 8'(sel_valid), 8'd0);
    pulse(0, 1);
    chk("r4_valid", 8'(sel_valid), 8'd1);
    chk("r4_ball", 8'(ball_sel), 8'(dflt_b()));
    chk("r4_gp", 8'(gp_sel), 8'(dflt_g()));
    chk("r4_ball_nz", 8'(ball_sel != 0), 8'd1);

    #2 reset = 0;
    #1 chk_zero("async");
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    pulse(0, 1);
    repeat (3) @(negedge clock);
    chk_zero("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/kick_input_latch.md
Name: kick_input_latch

Overview:
- Upstream stage of the penalty-kick animation block; the animation block consumes `ball_sel` and `gp_sel` as its `user1` and `user2` inputs.
- Per round, the block debounces the kicker's and goalkeeper's raw 2-bit switch inputs.
- Each player's first valid lane choice is captured during the countdown window.
- At window close the captured pair is frozen and presented for the rest of the round.
- The freeze keeps either player from changing or peeking after the countdown ends.

Parameters:
- DEB_TICKS, 20, number of consecutive `sample_tick` samples a raw value must hold before it is accepted (20 = 2 ms at 10 kHz).
- DEFAULT_LANE, 2, lane substituted for a player who made no choice (legal range 1-3).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- sample_tick  in  1  one-cycle enable pulse from the 10 kHz divider; debounce logic advances only on this pulse.
- round_start  in  1  one-cycle pulse; opens a new round (driven from the round-reset logic).
- window_close  in  1  one-cycle pulse; countdown reached zero (start).
- ball_raw  in  2  kicker switches; 0 = none, 1-3 = lane.
- gp_raw  in  2  goalkeeper switches; 0 = none, 1-3 = lane.
- ball_sel  out  2  frozen kicker lane, 1-3.
- gp_sel  out  2  frozen goalkeeper lane, 1-3.
- sel_valid  out  1  high while the frozen pair is valid.
- kicker_ready  out  1  kicker has a captured choice in the current window.
- keeper_ready  out  1  goalkeeper has a captured choice in the current window.

Behaviour:
- Reset state: all outputs 0; FSM in IDLE; synchronizers, debounce counters and hold registers cleared.
- Input conditioning: each raw bus passes through a 2-flop synchronizer. The debounced value updates only after DEB_TICKS consecutive sample_ticks with an identical synchronized value. Any change restarts the counter. The counter saturates and does not wrap.
- FSM states: IDLE, ARMED, LOCKED.
- IDLE:
  - Outputs hold their last values (0 after reset).
  - round_start → ARMED.
  - window_close is ignored.
- ARMED:
  - On entry, hold registers and both ready flags are cleared, and sel_valid drops the same cycle.
  - The first nonzero debounced value per player is written to that player's hold register, and its ready flag sets on the next clock.
  - Later changes to that player's input are ignored (first choice wins).
  - window_close → LOCKED.
- LOCKED:
  - `ball_sel`/`gp_sel` are loaded from the hold registers, one cycle after window_close. An empty hold register (0) is replaced by DEFAULT_LANE.
  - sel_valid is 1 and stays high until the next round_start.
  - Ready flags hold.
  - round_start → ARMED.
- Simultaneous pulses: round_start and window_close in the same cycle → round_start wins (enter or re-enter ARMED); window_close is dropped.
- round_start while in ARMED: restarts the window and clears the holds.
- Raw value 0 during ARMED: never captured.
- Debounced nonzero value in the same cycle as window_close: that value is captured and used.
- ball_sel/gp_sel are never 0 while sel_valid=1.
- Asynchronous reset asserted mid-round: the block returns to IDLE immediately. No output change follows until reset is released and a round_start arrives.

Optional Feature:
- Macro: KICK_RAND_DEFAULT_EN.
- When defined:
  - An 8-bit maximal LFSR (taps 8,6,5,4, seed 8'hA5 on reset) advances every clock.
  - A missing choice at lock time takes (lfsr[1:0]==0 ? 1 : lfsr[1:0]) instead of DEFAULT_LANE.
  - Kicker and keeper use different LFSR bit pairs ([1:0] and [3:2]).
- When undefined: DEFAULT_LANE is always used and no LFSR logic exists.

Decomposition:
- Shared package: lane encoding constants (LANE_NONE=0, LANE_LEFT=1, LANE_MID=2, LANE_RIGHT=3), the FSM state typedef, and the LFSR seed/taps.
- Sub-module `lane_debounce`: synchronizer plus debounce counter for one 2-bit bus, parameterised by DEB_TICKS. Instantiated twice.

Test Plan:
- Reset, then round_start; ball_raw=2 held for 20 ticks; gp_raw=3 held for 20 ticks; window_close → next cycle ball_sel=2, gp_sel=3, sel_valid=1.
- ball_raw toggles 1↔2 every 5 ticks for 100 ticks, then window_close → kicker_ready=0, ball_sel=DEFAULT_LANE (2) when KICK_RAND_DEFAULT_EN is undefined.
- After capture, with ball_raw=1 debounced, switch to 3 and hold 40 ticks → ball_sel=1 at lock (first choice wins).
- round_start and window_close pulsed in the same cycle → state ARMED, sel_valid=0, holds cleared.
- Reset asserted in LOCKED with sel_valid=1 → all outputs 0 asynchronously; after release, window_close alone produces no change.
- KICK_RAND_DEFAULT_EN defined, no inputs, lock after a known cycle count → ball_sel/gp_sel match the LFSR-derived values from seed A5 and are never 0.
